branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- EX-stage controller that owns the RV32I branch comparator (cmp) and sequences branch resolution for the pipeline.
- Accepts one branch at a time over a valid/ready handshake, registers operands, and resolves taken/not-taken plus target.
- On misprediction, drives a held redirect to fetch and a counted flush of younger stages.
- Sits between decode/EX issue and the fetch PC-select / pipeline-squash logic.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays asserted after a mispredict (1..7).
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  branch presented
- req_ready  out  1  controller can accept
- req_cmpop  in  3  branch_funct3_t condition
- req_rs1  in  32  operand a
- req_rs2  in  32  operand b
- req_pc  in  32  branch PC
- req_offset  in  32  sign-extended B-immediate
- req_pred_taken  in  1  fetch-stage prediction
- resolve_valid  out  1  one-cycle pulse: branch resolved
- resolve_taken  out  1  actual outcome, valid with resolve_valid
- mispredict  out  1  pulse with resolve_valid when outcome != prediction
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  32  corrected PC
- redirect_ack  in  1  fetch accepted redirect
- flush  out  1  squash younger stages

Behaviour:
- Reset: state IDLE; req_ready=1; resolve_valid, resolve_taken, mispredict, redirect_valid, flush = 0; redirect_pc = 0; operand registers = 0; flush counter = 0.
- FSM states: IDLE, EVAL, REDIRECT.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, capture all req_* fields and go to EVAL.
- EVAL (one cycle after accept):
  - req_ready=0.
  - cmp is driven from the registered operands.
  - resolve_valid=1 and resolve_taken = cmp result.
  - mispredict = resolve_taken ^ pred_taken.
  - Next-PC target: if taken, pc+offset; else pc+4. Both sums are modulo 2^32, so wrap-around is legal and not flagged.
  - If mispredict, go to REDIRECT and load the flush counter with FLUSH_CYCLES. Otherwise go to IDLE.
- REDIRECT:
  - redirect_valid=1, with redirect_pc held stable until acknowledged.
  - flush=1 while counter != 0; counter decrements each cycle.
  - Exit to IDLE when redirect_ack has been seen (including an ack in the first REDIRECT cycle) and counter==0. redirect_valid drops on the cycle after the ack.
  - If the ack arrives while counter > 0, redirect_valid deasserts but the state remains REDIRECT until counter==0.
- Latency: accept in cycle N, resolve in N+1, redirect_valid first high in N+2.
- req_valid outside IDLE is ignored (ready=0); the requester must hold its request.
- Illegal cmpop (3'b010, 3'b011): the cmp result is 0, so the branch resolves not-taken with no fault. It mispredicts only if predicted taken.
- Reset asserted mid-EVAL or mid-REDIRECT: all outputs return to reset values immediately (async) and the in-flight branch is dropped.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds output ports stat_branches (32 bits) and stat_mispredicts (32 bits).
  - Each counter increments on every resolve_valid / mispredict pulse, saturates at 32'hFFFF_FFFF, and resets to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- rv32i_types package:
  - branch_ctrl_state_t enum (IDLE, EVAL, REDIRECT).
  - Constant BR_FLUSH_W = 3 for the flush counter width.
  - Reuse the existing branch_funct3_t and rv32i_word.
- Sub-module: one instance of cmp (a = rs1 reg, b = rs2 reg, cmpop = cmpop reg).
- All sequencing stays in branch_resolve_ctrl.

Test Plan:
- beq, rs1=rs2=0x1234, pc=0x100, off=0x20, pred=1 -> N+1: resolve_taken=1, mispredict=0; no redirect; req_ready=1 at N+2.
- blt, rs1=0xFFFFFFFF, rs2=1, pc=0x200, off=0xFFFFFFF0, pred=0 -> taken, mispredict=1; redirect_pc=0x1F0; flush high 2 cycles; ack at N+2 -> IDLE at N+4.
- bltu with the same operands, pred=1 -> not taken, mispredict; redirect_pc=0x204.
- Wrap: bgeu, 5 vs 5, pc=0xFFFFFFF0, off=0x20, pred=0 -> redirect_pc=0x00000010.
- Ack withheld 10 cycles with FLUSH_CYCLES=2 -> flush low after 2 cycles; redirect_valid and redirect_pc stable until ack; req_ready=0 throughout.
- rst_n pulsed low during REDIRECT -> redirect_valid=flush=0 immediately; a following beq accepted normally. With BRANCH_STATS_EN: counters read 0 after reset, then 1/0.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// rv32i_types: shared RV32I word/branch-condition types and branch controller FSM encoding.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_funct3_t;
    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} branch_ctrl_state_t;
    localparam int BR_FLUSH_W = 3;
endpackage

// File: rtl/branch_resolve_ctrl_cmp.sv
// cmp: RV32I branch condition evaluator; reserved funct3 encodings resolve not-taken.
module cmp
    import rv32i_types::*;
(
    input  branch_funct3_t cmpop,
    input  rv32i_word      a,
    input  rv32i_word      b,
    output logic           br_en
);
    always_comb begin
        case (cmpop)
            BR_BEQ:  br_en = a == b;
            BR_BNE:  br_en = a != b;
            BR_BLT:  br_en = $signed(a) < $signed(b);
            BR_BGE:  br_en = $signed(a) >= $signed(b);
            BR_BLTU: br_en = a < b;
            BR_BGEU: br_en = a >= b;
            default: br_en = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: EX-stage branch resolution, redirect and counted flush sequencing.
// Define BRANCH_STATS_EN to add saturating resolve/mispredict counters.
module branch_resolve_ctrl
    import rv32i_types::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      req_valid,
    output logic      req_ready,
    input  logic [2:0] req_cmpop,
    input  rv32i_word req_rs1,
    input  rv32i_word req_rs2,
    input  rv32i_word req_pc,
    input  rv32i_word req_offset,
    input  logic      req_pred_taken,
    output logic      resolve_valid,
    output logic      resolve_taken,
    output logic      mispredict,
    output logic      redirect_valid,
    output rv32i_word redirect_pc,
    input  logic      redirect_ack,
    output logic      flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);
    branch_ctrl_state_t    state_q, state_d;
    branch_funct3_t        cmpop_q;
    logic [XLEN-1:0]       rs1_q, rs2_q, pc_q, off_q;
    logic                  pred_q;
    logic [BR_FLUSH_W-1:0] cnt_q, cnt_d;
    logic                  acked_q, acked_d;
    rv32i_word             redirect_pc_q, redirect_pc_d;
    logic                  br_en;
    logic                  accept;

    cmp u_cmp (
        .cmpop (cmpop_q),
        .a     (rs1_q),
        .b     (rs2_q),
        .br_en (br_en)
    );

    assign accept = state_q == IDLE && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cmpop_q       <= BR_BEQ;
            rs1_q         <= '0;
            rs2_q         <= '0;
            pc_q          <= '0;
            off_q         <= '0;
            pred_q        <= 1'b0;
            cnt_q         <= '0;
            acked_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acked_q       <= acked_d;
            redirect_pc_q <= redirect_pc_d;
            if (accept) begin
                cmpop_q <= branch_funct3_t'(req_cmpop);
                rs1_q   <= req_rs1;
                rs2_q   <= req_rs2;
                pc_q    <= req_pc;
                off_q   <= req_offset;
                pred_q  <= req_pred_taken;
            end
        end
    end

    // Leave REDIRECT on the edge where the counter reaches zero, provided the ack is in.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acked_d       = state_q == REDIRECT && (acked_q || redirect_ack);
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            IDLE: state_d = accept ? EVAL : IDLE;
            EVAL: begin
                state_d = mispredict ? REDIRECT : IDLE;
                if (mispredict) begin
                    cnt_d         = BR_FLUSH_W'(FLUSH_CYCLES);
                    redirect_pc_d = br_en ? pc_q + off_q : pc_q + XLEN'(4);
                end
            end
            REDIRECT: begin
                cnt_d   = cnt_q != '0 ? cnt_q - BR_FLUSH_W'(1) : cnt_q;
                state_d = (acked_q || redirect_ack) && cnt_q <= BR_FLUSH_W'(1) ? IDLE : REDIRECT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = state_q == IDLE;
        resolve_valid  = state_q == EVAL;
        resolve_taken  = state_q == EVAL && br_en;
        mispredict     = state_q == EVAL && (br_en ^ pred_q);
        redirect_valid = state_q == REDIRECT && !acked_q;
        flush          = state_q == REDIRECT && cnt_q != '0;
        redirect_pc    = redirect_pc_q;
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (resolve_valid && stat_br_q != '1)
                stat_br_q <= stat_br_q + 32'd1;
            if (mispredict && stat_mis_q != '1)
                stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed branches checked against a timeline model of resolve/redirect/flush.
module tb_branch_resolve_ctrl;
    localparam int F = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_cmpop = 3'b000;
    logic [31:0] req_rs1 = '0, req_rs2 = '0, req_pc = '0, req_offset = '0;
    logic        req_pred_taken = 1'b0;
    logic        resolve_valid, resolve_taken, mispredict;
    logic        redirect_valid, flush;
    logic [31:0] redirect_pc;
    logic        redirect_ack = 1'b0;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.FLUSH_CYCLES(F), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmpop      (req_cmpop),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_pc         (req_pc),
        .req_offset     (req_offset),
        .req_pred_taken (req_pred_taken),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .mispredict     (mispredict),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ack   (redirect_ack),
        .flush          (flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit ref_taken(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Model: m_t counts cycles since accept (1 = resolve cycle); busy ends at max(ack+1, F+2).
    bit          m_act = 0, m_mis = 0, m_taken = 0, m_acked = 0;
    int          m_t = 0, m_ta = 0;
    logic [31:0] m_target = '0;
    int unsigned m_br = 0, m_mc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_acked = 0; m_mis = 0; m_br = 0; m_mc = 0;
        end else if (!m_act) begin
            if (req_valid) begin
                m_act    = 1;
                m_t      = 1;
                m_acked  = 0;
                m_taken  = ref_taken(req_cmpop, req_rs1, req_rs2);
                m_mis    = m_taken != req_pred_taken;
                m_target = m_taken ? req_pc + req_offset : req_pc + 32'd4;
            end
        end else begin
            if (m_t == 1) begin
                m_br++;
                if (m_mis) m_mc++;
            end
            if (m_mis && m_t >= 2 && !m_acked && redirect_ack) begin
                m_acked = 1;
                m_ta    = m_t;
            end
            m_t++;
            if (!m_mis || (m_acked && m_t >= ((m_ta + 1 > F + 2) ? m_ta + 1 : F + 2)))
                m_act = 0;
        end
    end

    logic e_rv, e_rd, e_fl;
    always @(negedge clk) begin
        e_rv = m_act && m_t == 1;
        e_rd = m_act && m_mis && m_t >= 2 && !m_acked;
        e_fl = m_act && m_mis && m_t >= 2 && m_t <= F + 1;
        check("req_ready", req_ready, !m_act);
        check("resolve_valid", resolve_valid, e_rv);
        check("resolve_taken", resolve_taken, e_rv && m_taken);
        check("mispredict", mispredict, e_rv && m_mis);
        check("redirect_valid", redirect_valid, e_rd);
        check("flush", flush, e_fl);
        if (e_rd) check("redirect_pc", redirect_pc, m_target);
`ifdef BRANCH_STATS_EN
        check("stat_branches", stat_branches, m_br);
        check("stat_mispredicts", stat_mispredicts, m_mc);
`endif
    end

    task automatic wait_idle();
        int k = 0;
        while (m_act && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (m_act) begin
            n_total++;
            $display("FAIL idle_timeout: model still busy after %0d cycles", k);
        end
    endtask

    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] pc, logic [31:0] off, bit pred);
        wait_idle();
        @(negedge clk);
        req_cmpop = op; req_rs1 = a; req_rs2 = b; req_pc = pc; req_offset = off;
        req_pred_taken = pred;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Ack asserted during cycle N+k; pins redirect_pc at N+2 and flush low from N+4 on.
    task automatic run_mis(string nm, logic [31:0] exp_pc, int k);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            if (i == 2) check({nm, "_pc"}, redirect_pc, exp_pc);
            if (i >= 4) check({nm, "_flush_off"}, flush, 1'b0);
        end
        redirect_ack = 1'b1;
        @(negedge clk);
        redirect_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        #2 rst_n = 1'b1;

        issue(3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b1);
        @(negedge clk);
        check("beq_taken", resolve_taken, 1'b1);
        check("beq_mis", mispredict, 1'b0);
        @(negedge clk);
        check("beq_ready", req_ready, 1'b1);
        check("beq_noredir", redirect_valid, 1'b0);

        issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF0, 1'b0);
        @(negedge clk);
        check("blt_taken", resolve_taken, 1'b1);
        check("blt_mis", mispredict, 1'b1);
        @(negedge clk);
        check("blt_pc", redirect_pc, 32'h1F0);
        check("blt_flush1", flush, 1'b1);
        redirect_ack = 1'b1;
        @(negedge clk);
        redirect_ack = 1'b0;
        check("blt_rv_drop", redirect_valid, 1'b0);
        check("blt_flush2", flush, 1'b1);
        @(negedge clk);
        check("blt_idle", req_ready, 1'b1);
        check("blt_flush_end", flush, 1'b0);

        issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'hFFFF_FFF0, 1'b1);
        run_mis("bltu", 32'h204, 2);
        issue(3'b111, 32'h5, 32'h5, 32'hFFFF_FFF0, 32'h20, 1'b0);
        run_mis("bgeu_wrap", 32'h10, 2);
        issue(3'b001, 32'h1, 32'h2, 32'h400, 32'h40, 1'b0);
        run_mis("bne_hold", 32'h440, 12);
        issue(3'b101, 32'h8000_0000, 32'h1, 32'h500, 32'h8, 1'b1);
        run_mis("bge_late", 32'h504, 3);
        issue(3'b010, 32'h7, 32'h7, 32'h600, 32'h10, 1'b1);
        run_mis("illegal_010", 32'h604, 3);
        issue(3'b011, 32'h7, 32'h7, 32'h700, 32'h10, 1'b0);
        @(negedge clk);
        check("illegal_011_taken", resolve_taken, 1'b0);
        check("illegal_011_mis", mispredict, 1'b0);

        issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h800, 32'h30, 1'b0);
        repeat (2) @(negedge clk);
        check("pre_rst_rv", redirect_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rv", redirect_valid, 1'b0);
        check("mid_rst_flush", flush, 1'b0);
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_pc", redirect_pc, 32'h0);
`ifdef BRANCH_STATS_EN
        check("mid_rst_stat_br", stat_branches, 32'd0);
        check("mid_rst_stat_mis", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(3'b000, 32'h9, 32'h9, 32'h900, 32'h4, 1'b1);
        @(negedge clk);
        check("post_rst_taken", resolve_taken, 1'b1);
        check("post_rst_resolve", resolve_valid, 1'b1);
        wait_idle();
`ifdef BRANCH_STATS_EN
        check("post_rst_stat_br", stat_branches, 32'd1);
        check("post_rst_stat_mis", stat_mispredicts, 32'd0);
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
